mar_burst: RTL and testbench

- Parametrised next-generation Memory Address Register for the Mini SRC CPU.
- Loads an address from the bus exactly as the basic MAR does.
- Also runs self-timed read/write bursts: it issues one RAM request per beat with a req/ack handshake and post-increments the address by a programmable stride.
- Sits between the bus, the control unit (Start/Done) and the RAM address/control inputs.

---
 rtl/mar_burst.sv | 144 ++++++++++++++
 tb/tb_mar_burst.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mar_burst.sv
// Memory address register with self-timed RAM bursts: bus load in IDLE, one req/ack beat per cycle in ACTIVE.
// Outputs are registered; MemReq appears the cycle after Start; each beat waits indefinitely for MemAck.
module mar_burst #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int MAX_BURST = 8,
    parameter int STRIDE    = 1,
    localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              Start,
    input  logic              Write,
    input  logic [LEN_W-1:0]  BurstLen,
    input  logic              MemAck,
    output logic [ADDR_W-1:0] Address,
    output logic              MemReq,
    output logic              MemWE,
    output logic [LEN_W-1:0]  Beat,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic             we;
        logic [LEN_W-1:0] len;
    } burst_cfg_t;

    state_t            state_q, state_d;
    burst_cfg_t        cfg_q, cfg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  beat_inc;

    assign beat_inc = beat_q + LEN_W'(1);

    // Only the low ADDR_W bits of the bus form an address.
    generate
        if (DATA_W > ADDR_W) begin : g_bus_hi
            logic unused_bus_bits;
            assign unused_bus_bits = ^BusMuxOut[DATA_W-1:ADDR_W];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        req_d   = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MARin) begin
                    addr_d = BusMuxOut[ADDR_W-1:0];
                end
                if (Start) begin
                    beat_d = '0;
                    if (BurstLen != '0) begin
                        cfg_d.we  = Write;
                        cfg_d.len = (BurstLen > MAX_LEN) ? MAX_LEN : BurstLen;
                        state_d   = S_ACTIVE;
                        req_d     = 1'b1;
                        we_d      = Write;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                req_d  = 1'b1;
                we_d   = cfg_q.we;
                busy_d = 1'b1;
                if (MemAck) begin
                    addr_d = addr_q + STRIDE_A;
                    beat_d = beat_inc;
                    // Last beat: drop the request and flag completion together.
                    if (beat_inc == cfg_q.len) begin
                        state_d = S_FINISH;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Address = addr_q;
    assign MemReq  = req_q;
    assign MemWE   = we_q;
    assign Beat    = beat_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_mar_burst.sv
// Bench for mar_burst: directed and random bursts checked against a transaction-level address/beat model.
module tb_mar_burst;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 9;
    localparam int MAX_BURST = 8;
    localparam int STRIDE    = 1;
    localparam int LEN_W     = $clog2(MAX_BURST + 1);
    localparam int TIMEOUT   = 200;

    logic              Clock = 1'b0;
    logic              Clear = 1'b0;
    logic [DATA_W-1:0] BusMuxOut = '0;
    logic              MARin = 1'b0;
    logic              Start = 1'b0;
    logic              Write = 1'b0;
    logic [LEN_W-1:0]  BurstLen = '0;
    logic              MemAck = 1'b0;
    logic [ADDR_W-1:0] Address;
    logic              MemReq;
    logic              MemWE;
    logic [LEN_W-1:0]  Beat;
    logic              Busy;
    logic              Done;

    int vectors = 0;
    int errors  = 0;

    mar_burst #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .STRIDE(STRIDE)
    ) dut (
        .Clock(Clock), .Clear(Clear), .BusMuxOut(BusMuxOut), .MARin(MARin),
        .Start(Start), .Write(Write), .BurstLen(BurstLen), .MemAck(MemAck),
        .Address(Address), .MemReq(MemReq), .MemWE(MemWE), .Beat(Beat),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // Address of beat k of a burst that began at a0.
    function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] a0, input int k);
        return ADDR_W'((int'(a0) + k * STRIDE) % (1 << ADDR_W));
    endfunction

    // load_mode: 0 = MARin in a prior cycle, 1 = MARin with Start, 2 = continue from current Address.
    // ack_mode: 0 = always ack, 1 = random ack, 2 = ack from pat bits (then always).
    task automatic do_burst(input logic [ADDR_W-1:0] a0, input logic wr, input logic [LEN_W-1:0] len,
                            input int load_mode, input int ack_mode, input logic [15:0] pat,
                            input bit intrude, input string tag);
        int n, k, cyc;
        logic ack;
        n = (int'(len) > MAX_BURST) ? MAX_BURST : int'(len);
        if (load_mode == 0) begin
            MARin = 1'b1;
            BusMuxOut = $urandom;
            BusMuxOut[ADDR_W-1:0] = a0;
            @(negedge Clock);
            MARin = 1'b0;
            BusMuxOut = $urandom;
            vectors++;
            if (Address !== a0) begin
                errors++;
                $display("FAIL %s preload: Address got %h expected %h", tag, Address, a0);
            end
        end
        Start = 1'b1;
        Write = wr;
        BurstLen = len;
        MARin = (load_mode == 1);
        if (load_mode == 1) begin
            BusMuxOut = $urandom;
            BusMuxOut[ADDR_W-1:0] = a0;
        end
        @(negedge Clock);
        Start = 1'b0;
        MARin = 1'b0;
        Write = $urandom;
        BurstLen = $urandom;
        if (n == 0) begin
            vectors++;
            if ({Done, MemReq, Busy, MemWE, Address} !== {1'b1, 1'b0, 1'b0, 1'b0, a0}) begin
                errors++;
                $display("FAIL %s zero_len: {Done,Req,Busy,WE,Addr} got %h expected %h", tag,
                         {Done, MemReq, Busy, MemWE, Address}, {1'b1, 1'b0, 1'b0, 1'b0, a0});
            end
        end else begin
            k = 0;
            cyc = 0;
            while (k < n && cyc < TIMEOUT) begin
                vectors++;
                if ({MemReq, MemWE, Busy, Done, Beat, Address} !==
                    {1'b1, wr, 1'b1, 1'b0, LEN_W'(k), model_addr(a0, k)}) begin
                    errors++;
                    $display("FAIL %s beat%0d cyc%0d: {Req,WE,Busy,Done,Beat,Addr} got %h expected %h",
                             tag, k, cyc, {MemReq, MemWE, Busy, Done, Beat, Address},
                             {1'b1, wr, 1'b1, 1'b0, LEN_W'(k), model_addr(a0, k)});
                end
                case (ack_mode)
                    0:       ack = 1'b1;
                    1:       ack = 1'($urandom);
                    default: ack = (cyc < 16) ? pat[cyc] : 1'b1;
                endcase
                MemAck = ack;
                if (intrude) begin
                    MARin = 1'($urandom);
                    Start = 1'($urandom);
                    BusMuxOut = 32'h0000_0055;
                    BurstLen = $urandom;
                end
                @(negedge Clock);
                if (ack) k++;
                cyc++;
            end
            MemAck = 1'b0;
            MARin = 1'b0;
            Start = 1'b0;
            vectors++;
            if (cyc >= TIMEOUT) begin
                errors++;
                $display("FAIL %s timeout: beats got %0d expected %0d", tag, k, n);
            end
            vectors++;
            if ({MemReq, MemWE, Busy, Done, Beat, Address} !==
                {1'b0, 1'b0, 1'b0, 1'b1, LEN_W'(n), model_addr(a0, n)}) begin
                errors++;
                $display("FAIL %s finish: {Req,WE,Busy,Done,Beat,Addr} got %h expected %h", tag,
                         {MemReq, MemWE, Busy, Done, Beat, Address},
                         {1'b0, 1'b0, 1'b0, 1'b1, LEN_W'(n), model_addr(a0, n)});
            end
        end
        MemAck = 1'($urandom);
        @(negedge Clock);
        MemAck = 1'b0;
        vectors++;
        if ({MemReq, Busy, Done, Address} !== {1'b0, 1'b0, 1'b0, model_addr(a0, n)}) begin
            errors++;
            $display("FAIL %s idle_after: {Req,Busy,Done,Addr} got %h expected %h", tag,
                     {MemReq, Busy, Done, Address}, {1'b0, 1'b0, 1'b0, model_addr(a0, n)});
        end
        if (n != 0) begin
            vectors++;
            if (Beat !== LEN_W'(n)) begin
                errors++;
                $display("FAIL %s beat_hold: Beat got %0d expected %0d", tag, Beat, n);
            end
        end
    endtask

    task automatic test_reset;
        MARin = 1'b1;
        Start = 1'b1;
        BurstLen = 4'd3;
        MemAck = 1'b1;
        BusMuxOut = 32'h1234_5678;
        repeat (3) @(negedge Clock);
        vectors++;
        if ({Address, MemReq, MemWE, Beat, Busy, Done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {Address, MemReq, MemWE, Beat, Busy, Done});
        end
        MARin = 1'b0;
        Start = 1'b0;
        MemAck = 1'b0;
        Clear = 1'b1;
        @(negedge Clock);
        vectors++;
        if ({Address, MemReq, Busy, Done} !== '0) begin
            errors++;
            $display("FAIL reset_release: got %h expected 0", {Address, MemReq, Busy, Done});
        end
    endtask

    task automatic test_load;
        MARin = 1'b1;
        BusMuxOut = 32'hFFFF_F1A5;
        @(negedge Clock);
        MARin = 1'b0;
        BusMuxOut = 32'h0;
        vectors++;
        if ({Address, MemReq, Busy, Done} !== {9'h1A5, 3'b000}) begin
            errors++;
            $display("FAIL load: {Addr,Req,Busy,Done} got %h expected %h", {Address, MemReq, Busy, Done},
                     {9'h1A5, 3'b000});
        end
        @(negedge Clock);
        vectors++;
        if (Address !== 9'h1A5) begin
            errors++;
            $display("FAIL load_hold: Address got %h expected 1a5", Address);
        end
    endtask

    task automatic test_read_burst;
        do_burst(9'h010, 1'b0, 4'd4, 0, 0, 16'h0, 1'b0, "read_cont");
    endtask

    task automatic test_write_wait;
        do_burst(9'h100, 1'b1, 4'd3, 0, 2, 16'b0000_0000_0011_0010, 1'b0, "write_wait");
    endtask

    task automatic test_edges;
        do_burst(9'h1FE, 1'b0, 4'd3, 0, 0, 16'h0, 1'b0, "wrap");
        do_burst(9'h0A7, 1'b1, 4'd0, 0, 0, 16'h0, 1'b0, "len_zero");
        do_burst(9'h020, 1'b1, 4'd15, 0, 1, 16'h0, 1'b0, "saturate");
        do_burst(9'h0C0, 1'b0, 4'd8, 0, 0, 16'h0, 1'b0, "max_len");
    endtask

    task automatic test_collision;
        do_burst(9'h0F0, 1'b1, 4'd5, 0, 1, 16'h0, 1'b1, "marin_ignored");
        do_burst(9'h040, 1'b0, 4'd1, 1, 0, 16'h0, 1'b0, "same_cycle");
    endtask

    task automatic test_back_to_back;
        do_burst(9'h030, 1'b1, 4'd2, 0, 0, 16'h0, 1'b0, "b2b_first");
        do_burst(9'h032, 1'b0, 4'd3, 2, 1, 16'h0, 1'b0, "b2b_follow");
    endtask

    task automatic test_random;
        logic [ADDR_W-1:0] a0;
        for (int i = 0; i < 25; i++) begin
            a0 = ADDR_W'($urandom);
            do_burst(a0, 1'($urandom), LEN_W'($urandom_range(0, 15)), $urandom_range(0, 1),
                     1, 16'h0, 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_burst;
        MARin = 1'b1;
        BusMuxOut = 32'h0000_0080;
        @(negedge Clock);
        MARin = 1'b0;
        Start = 1'b1;
        Write = 1'b1;
        BurstLen = 4'd4;
        @(negedge Clock);
        Start = 1'b0;
        MemAck = 1'b1;
        repeat (2) @(negedge Clock);
        vectors++;
        if ({MemReq, Beat, Address} !== {1'b1, 4'd2, 9'h082}) begin
            errors++;
            $display("FAIL mid_pre: {Req,Beat,Addr} got %h expected %h", {MemReq, Beat, Address},
                     {1'b1, 4'd2, 9'h082});
        end
        #2 Clear = 1'b0;
        #1;
        vectors++;
        if ({Address, MemReq, MemWE, Beat, Busy, Done} !== '0) begin
            errors++;
            $display("FAIL mid_async: got %h expected 0", {Address, MemReq, MemWE, Beat, Busy, Done});
        end
        @(negedge Clock);
        Clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            vectors++;
            if ({MemReq, MemWE, Busy, Done, Beat, Address} !== '0) begin
                errors++;
                $display("FAIL mid_after%0d: got %h expected 0", i,
                         {MemReq, MemWE, Busy, Done, Beat, Address});
            end
        end
        MemAck = 1'b0;
    endtask

    initial begin
        @(negedge Clock);
        test_reset();
        test_load();
        test_read_burst();
        test_write_wait();
        test_edges();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
